pipeline_rr_arbiter: RTL and testbench

- N-to-1 round-robin arbiter that shares one valid/ready pipeline register slot among N_REQ upstream requesters.
- Selects one valid requester per cycle and captures its beat into the output register, tagged with the source id.
- Drives a single downstream valid/ready channel, with one-cycle latency and full throughput.
- Sits in front of the single-stage pipeline register path wherever several producers feed one consumer.

---
 rtl/pipeline_rr_arbiter_if.sv | 28 ++
 rtl/pipeline_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_pipeline_rr_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipeline_rr_arbiter_if.sv
// pipeline_rr_arbiter_if: upstream request bundle plus the single downstream
// valid/ready channel of pipeline_rr_arbiter.
//   master: drives in_data/in_valid/out_ready, observes in_ready/out_*/grant
//   slave : the arbiter side of the same signals
interface pipeline_rr_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = $clog2(N_REQ)
);
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ-1:0]        in_ready;
  logic [DATA_W-1:0]       out_data;
  logic [ID_W-1:0]         out_id;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_REQ-1:0]        grant;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_id, out_valid, grant
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_id, out_valid, grant
  );
endinterface

// File: rtl/pipeline_rr_arbiter.sv
// pipeline_rr_arbiter: N_REQ-to-1 round-robin arbiter feeding one registered
// valid/ready slot; one-cycle latency, full throughput, beats tagged with id.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       pipeline_rr_arbiter_if.slave:
//               in_data/in_valid/in_ready  per-requester upstream channels
//               out_data/out_id/out_valid  registered output beat
//               out_ready                  downstream accept
//               grant                      one-hot combinational grant
// Optional: define ARB_BURST_EN to keep the grant on one requester for up to
// MAX_BURST consecutive beats.
module pipeline_rr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ID_W      = $clog2(N_REQ),
  parameter int unsigned MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_rr_arbiter_if.slave bus
);

  localparam int unsigned SUM_W = ID_W + 1;
  localparam int unsigned CNT_W = 8;

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("pipeline_rr_arbiter: N_REQ out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("pipeline_rr_arbiter: MAX_BURST out of range");
  end

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   g;
  logic [ID_W-1:0]   g_inc;
  logic [SUM_W-1:0]  sum;
  logic              found;
  logic              slot_free;
  logic              accept;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  in_ready;
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic [DATA_W-1:0] out_data_q;
  logic [ID_W-1:0]   out_id_q;
  logic              out_valid_q;

  // Rotating priority search: first valid requester starting at ptr.
  always_comb begin
    found = 1'b0;
    g     = '0;
    sum   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      sum = {1'b0, ptr} + SUM_W'(k);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      if (!found && bus.in_valid[ID_W'(sum)]) begin
        found = 1'b1;
        g     = ID_W'(sum);
      end
    end
  end

  // Grant is suppressed during reset so nothing is accepted then.
  always_comb begin
    grant = '0;
    if (found && !rst) grant[g] = 1'b1;
  end

  // Unpack the flat data bus per requester.
  always_comb begin
    for (int i = 0; i < int'(N_REQ); i++) begin
      data_arr[i] = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = grant & {N_REQ{slot_free}};
  assign accept    = |(bus.in_valid & in_ready);
  assign g_inc     = (g == ID_W'(N_REQ - 1)) ? '0 : g + ID_W'(1);

  // Output slot: load on accept, otherwise empty when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= data_arr[g];
      out_id_q    <= g;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef ARB_BURST_EN
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W:0]   cnt_inc;
  logic             burst_more;

  // Burst count only continues when the current owner is granted again.
  always_comb begin
    cnt_base   = (g == ptr) ? burst_cnt : '0;
    cnt_inc    = {1'b0, cnt_base} + (CNT_W+1)'(1);
    burst_more = cnt_inc < (CNT_W+1)'(MAX_BURST);
  end

  // Pointer stays on the owner until its burst allowance is used up.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      if (burst_more) begin
        ptr       <= g;
        burst_cnt <= cnt_inc[CNT_W-1:0];
      end else begin
        ptr       <= g_inc;
        burst_cnt <= '0;
      end
    end
  end
`else
  // Pointer moves past the winner after every accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= g_inc;
    end
  end
`endif

  assign bus.grant     = grant;
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// tb_pipeline_rr_arbiter: table-driven directed bench for pipeline_rr_arbiter
// (N_REQ=4, DATA_W=8). Each row applies inputs for one cycle, checks the
// combinational grant/in_ready before the edge and the registered output after.
// With ARB_BURST_EN defined the burst table (MAX_BURST=2) is used instead.
module tb_pipeline_rr_arbiter;

`ifdef ARB_BURST_EN
  localparam int unsigned MAX_B = 2;
`else
  localparam int unsigned MAX_B = 4;
`endif

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  eg;
    logic [3:0]  eir;
    logic        eov;
    logic [7:0]  eod;
    logic [1:0]  eid;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  vec_t tbl[$];

  pipeline_rr_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  pipeline_rr_arbiter #(
    .N_REQ(4), .DATA_W(8), .ID_W(2), .MAX_BURST(MAX_B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] iv, input logic [31:0] d,
                     input logic ordy, input logic [3:0] eg, input logic [3:0] eir,
                     input logic eov, input logic [7:0] eod, input logic [1:0] eid);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eg = eg; v.eir = eir; v.eov = eov; v.eod = eod; v.eid = eid;
    tbl.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    //   rst iv       data          ordy grant    in_ready ov    od     id
    add(1, 4'b0011, 32'h0000B1B0, 1, 4'b0000, 4'b0000, 0, 8'h00, 2'd0);
    add(1, 4'b0011, 32'h0000B1B0, 1, 4'b0000, 4'b0000, 0, 8'h00, 2'd0);
`ifdef ARB_BURST_EN
    // Two-beat bursts alternate between requesters 0 and 1.
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0001, 4'b0001, 1, 8'hB0, 2'd0);
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0001, 4'b0001, 1, 8'hB0, 2'd0);
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0010, 4'b0010, 1, 8'hB1, 2'd1);
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0010, 4'b0010, 1, 8'hB1, 2'd1);
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0001, 4'b0001, 1, 8'hB0, 2'd0);
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0001, 4'b0001, 1, 8'hB0, 2'd0);
    // Requester 0 gets one beat then drops valid: grant moves to 1.
    add(0, 4'b0001, 32'h0000B1B0, 1, 4'b0001, 4'b0001, 1, 8'hB0, 2'd0);
    add(0, 4'b0010, 32'h0000B1B0, 1, 4'b0010, 4'b0010, 1, 8'hB1, 2'd1);
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0010, 4'b0010, 1, 8'hB1, 2'd1);
    add(0, 4'b0011, 32'h0000B1B0, 1, 4'b0001, 4'b0001, 1, 8'hB0, 2'd0);
`else
    // Single beat from requester 2, then drain with nothing valid.
    add(0, 4'b0100, 32'h00550000, 1, 4'b0100, 4'b0100, 1, 8'h55, 2'd2);
    add(0, 4'b0000, 32'h00000000, 1, 4'b0000, 4'b0000, 0, 8'h55, 2'd2);
    // All valid: search resumes at 3, then rotates with no bubbles.
    add(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 4'b1000, 1, 8'hA3, 2'd3);
    add(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 4'b0001, 1, 8'hA0, 2'd0);
    add(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 4'b0010, 1, 8'hA1, 2'd1);
    add(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 4'b0100, 1, 8'hA2, 2'd2);
    add(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 4'b1000, 1, 8'hA3, 2'd3);
    add(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 4'b0001, 1, 8'hA0, 2'd0);
    add(0, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 4'b0010, 1, 8'hA1, 2'd1);
    // Beat 0x11 from requester 1, then 5 stalled cycles with 0 and 3 valid.
    add(0, 4'b0010, 32'h00001100, 1, 4'b0010, 4'b0010, 1, 8'h11, 2'd1);
    for (int i = 0; i < 5; i++)
      add(0, 4'b1001, 32'hD30000B0, 0, 4'b1000, 4'b0000, 1, 8'h11, 2'd1);
    add(0, 4'b1001, 32'hD30000B0, 1, 4'b1000, 4'b1000, 1, 8'hD3, 2'd3);
    // Move ptr to 3, then only requester 1 valid: wraps and skips to 1.
    add(0, 4'b0100, 32'h00C20000, 1, 4'b0100, 4'b0100, 1, 8'hC2, 2'd2);
    add(0, 4'b0010, 32'h0000E100, 1, 4'b0010, 4'b0010, 1, 8'hE1, 2'd1);
    // ptr is now 2: 2 and 3 idle, so requester 0 wins over 1.
    add(0, 4'b0011, 32'h0000F1F0, 1, 4'b0001, 4'b0001, 1, 8'hF0, 2'd0);
    // Stall, then reset mid-stall: beat dropped and ptr back to 0.
    add(0, 4'b0000, 32'h00000000, 0, 4'b0000, 4'b0000, 1, 8'hF0, 2'd0);
    add(1, 4'b1001, 32'hD30000B0, 0, 4'b0000, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'b1001, 32'hD30000B0, 1, 4'b0001, 4'b0001, 1, 8'hB0, 2'd0);
    add(0, 4'b0000, 32'h00000000, 1, 4'b0000, 4'b0000, 0, 8'hB0, 2'd0);
`endif

    foreach (tbl[r]) begin
      rst           = tbl[r].rst;
      bus.in_valid  = tbl[r].iv;
      bus.in_data   = tbl[r].d;
      bus.out_ready = tbl[r].ordy;
      #1;
      chk("grant",    r, 32'(bus.grant),    32'(tbl[r].eg));
      chk("in_ready", r, 32'(bus.in_ready), 32'(tbl[r].eir));
      @(posedge clk);
      #1;
      chk("out_valid", r, 32'(bus.out_valid), 32'(tbl[r].eov));
      chk("out_data",  r, 32'(bus.out_data),  32'(tbl[r].eod));
      chk("out_id",    r, 32'(bus.out_id),    32'(tbl[r].eid));
    end

    // Hand sequence: held beat never reappears after reset clears it.
    rst           = 1'b0;
    bus.in_valid  = 4'b0100;
    bus.in_data   = 32'h00770000;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("seq_load_valid", -1, 32'(bus.out_valid), 32'd1);
    chk("seq_load_data",  -1, 32'(bus.out_data),  32'h77);
    rst          = 1'b1;
    bus.in_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("seq_no_ghost", c, 32'(bus.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
